// File: rtl/ex_mem_reg_pkg.sv
// ex_mem_reg_pkg: CP0 exception codes, handler PC and the exception-priority merge
// shared by the pipeline registers and CP0.
package ex_mem_reg_pkg;

    localparam int EXC_CODE_W = 5;
    localparam logic [31:0] PC_HANDLER = 32'h0000_4180;

    localparam logic [EXC_CODE_W-1:0] EXC_INT     = 5'd0;
    localparam logic [EXC_CODE_W-1:0] EXC_ADEL    = 5'd4;
    localparam logic [EXC_CODE_W-1:0] EXC_ADES    = 5'd5;
    localparam logic [EXC_CODE_W-1:0] EXC_SYSCALL = 5'd8;
    localparam logic [EXC_CODE_W-1:0] EXC_RI      = 5'd10;
    localparam logic [EXC_CODE_W-1:0] EXC_OV      = 5'd12;

    typedef struct packed {
        logic                  vld;
        logic [EXC_CODE_W-1:0] code;
    } exc_t;

    // Upstream exceptions win; the raw add/sub overflow only matters for address calculation.
    function automatic exc_t exc_merge(
        input logic                  up_vld,
        input logic [EXC_CODE_W-1:0] up_code,
        input logic                  ov,
        input logic                  esl,
        input logic                  is_load,
        input logic                  is_store
    );
        exc_t r;
        r.vld  = up_vld | ov | (esl & (is_load | is_store));
        r.code = up_vld              ? up_code  :
                 ov                  ? EXC_OV   :
                 (esl & is_load)     ? EXC_ADEL :
                 (esl & is_store)    ? EXC_ADES : EXC_INT;
        return r;
    endfunction

endpackage

// File: rtl/ex_mem_reg_if.sv
// ex_mem_reg_if: E-stage inputs, pipeline controls and M-stage outputs of the E->M register.
interface ex_mem_reg_if #(
    parameter int EXC_W = ex_mem_reg_pkg::EXC_CODE_W
);

    logic             req;
    logic             en;
    logic             clr;
    logic [31:0]      pc_E;
    logic [31:0]      instr_E;
    logic [31:0]      alu_ans_E;
    logic             alu_ov_E;
    logic             alu_esl_E;
    logic             is_load_E;
    logic             is_store_E;
    logic [31:0]      rt_data_E;
    logic [4:0]       wa_E;
    logic             bd_E;
    logic             exc_vld_E;
    logic [EXC_W-1:0] exc_E;
    logic [31:0]      pc_M;
    logic [31:0]      instr_M;
    logic [31:0]      ans_M;
    logic [31:0]      rt_data_M;
    logic [4:0]       wa_M;
    logic             bd_M;
    logic             exc_vld_M;
    logic [EXC_W-1:0] exc_M;
    logic             valid_M;

    modport master (
        output req, en, clr, pc_E, instr_E, alu_ans_E, alu_ov_E, alu_esl_E, is_load_E,
               is_store_E, rt_data_E, wa_E, bd_E, exc_vld_E, exc_E,
        input  pc_M, instr_M, ans_M, rt_data_M, wa_M, bd_M, exc_vld_M, exc_M, valid_M
    );

    modport slave (
        input  req, en, clr, pc_E, instr_E, alu_ans_E, alu_ov_E, alu_esl_E, is_load_E,
               is_store_E, rt_data_E, wa_E, bd_E, exc_vld_E, exc_E,
        output pc_M, instr_M, ans_M, rt_data_M, wa_M, bd_M, exc_vld_M, exc_M, valid_M
    );

endinterface

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: E->M pipeline register with hold, bubble, flush and ALU-exception folding.
module ex_mem_reg #(
    parameter logic [31:0] PC_HANDLER = ex_mem_reg_pkg::PC_HANDLER,
    parameter int          EXC_W      = ex_mem_reg_pkg::EXC_CODE_W
) (
    input logic         clk,
    input logic         reset,
    ex_mem_reg_if.slave bus
);

    import ex_mem_reg_pkg::*;

    exc_t m;

    assign m = exc_merge(bus.exc_vld_E, EXC_CODE_W'(bus.exc_E), bus.alu_ov_E,
                         bus.alu_esl_E, bus.is_load_E, bus.is_store_E);

    // Reset, flush and bubble all clear the payload; they differ only in pc/bd.
    always_ff @(posedge clk) begin
        if (reset || bus.req || (bus.en && bus.clr)) begin
            bus.pc_M      <= reset ? '0 : bus.req ? PC_HANDLER : bus.pc_E;
            bus.bd_M      <= !reset && !bus.req && bus.bd_E;
            bus.instr_M   <= '0;
            bus.ans_M     <= '0;
            bus.rt_data_M <= '0;
            bus.wa_M      <= '0;
            bus.exc_vld_M <= 1'b0;
            bus.exc_M     <= '0;
            bus.valid_M   <= 1'b0;
        end else if (bus.en) begin
            bus.pc_M      <= bus.pc_E;
            bus.bd_M      <= bus.bd_E;
            bus.instr_M   <= bus.instr_E;
            bus.ans_M     <= bus.alu_ans_E;
            bus.rt_data_M <= bus.rt_data_E;
            bus.wa_M      <= m.vld ? 5'd0 : bus.wa_E;
            bus.exc_vld_M <= m.vld;
            bus.exc_M     <= EXC_W'(m.code);
            bus.valid_M   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: directed and randomized checks of ex_mem_reg against a behavioural model.
module tb_ex_mem_reg;

    typedef struct {
        logic [31:0] pc, instr, ans, rt;
        logic [4:0]  wa;
        logic        bd, ev;
        logic [4:0]  ec;
        logic        v;
    } st_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_pass = 0;
    st_t  exp_s;

    ex_mem_reg_if bus ();

    ex_mem_reg dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    // Next state derived straight from the stage's rules, one case at a time.
    function automatic st_t model(input st_t cur);
        st_t n;
        int  code;
        n = '{pc: 0, instr: 0, ans: 0, rt: 0, wa: 0, bd: 0, ev: 0, ec: 0, v: 0};
        if (reset) return n;
        if (bus.req) begin
            n.pc = 32'h0000_4180;
            return n;
        end
        if (!bus.en) return cur;
        n.pc = bus.pc_E;
        n.bd = bus.bd_E;
        if (bus.clr) return n;
        if (bus.exc_vld_E) code = int'(bus.exc_E);
        else if (bus.alu_ov_E) code = 12;
        else if (bus.is_load_E && bus.alu_esl_E) code = 4;
        else if (bus.is_store_E && bus.alu_esl_E) code = 5;
        else code = -1;
        n.instr = bus.instr_E;
        n.ans   = bus.alu_ans_E;
        n.rt    = bus.rt_data_E;
        n.ev    = code >= 0;
        n.ec    = n.ev ? 5'(code) : 5'd0;
        n.wa    = n.ev ? 5'd0 : bus.wa_E;
        n.v     = 1'b1;
        return n;
    endfunction

    task automatic step();
        st_t nxt;
        nxt = model(exp_s);
        @(posedge clk);
        #1;
        exp_s = nxt;
        check("pc_M", bus.pc_M, exp_s.pc);
        check("instr_M", bus.instr_M, exp_s.instr);
        check("ans_M", bus.ans_M, exp_s.ans);
        check("rt_data_M", bus.rt_data_M, exp_s.rt);
        check("wa_M", 32'(bus.wa_M), 32'(exp_s.wa));
        check("bd_M", 32'(bus.bd_M), 32'(exp_s.bd));
        check("exc_vld_M", 32'(bus.exc_vld_M), 32'(exp_s.ev));
        check("exc_M", 32'(bus.exc_M), 32'(exp_s.ec));
        check("valid_M", 32'(bus.valid_M), 32'(exp_s.v));
    endtask

    task automatic rand_data();
        bus.pc_E       = $urandom & 32'hffff_fffc;
        bus.instr_E    = $urandom;
        bus.alu_ans_E  = $urandom;
        bus.rt_data_E  = $urandom;
        bus.wa_E       = 5'($urandom);
        bus.bd_E       = 1'($urandom);
        bus.alu_ov_E   = $urandom_range(0, 5) == 0;
        bus.alu_esl_E  = $urandom_range(0, 2) == 0;
        bus.is_load_E  = $urandom_range(0, 2) == 0;
        bus.is_store_E = $urandom_range(0, 2) == 0;
        bus.exc_vld_E  = $urandom_range(0, 5) == 0;
        bus.exc_E      = 5'($urandom);
    endtask

    task automatic plain(input logic [31:0] ans, input logic [4:0] wa);
        {bus.req, bus.clr, bus.alu_ov_E, bus.alu_esl_E} = '0;
        {bus.is_load_E, bus.is_store_E, bus.exc_vld_E, bus.bd_E} = '0;
        bus.en        = 1'b1;
        bus.exc_E     = '0;
        bus.alu_ans_E = ans;
        bus.wa_E      = wa;
        bus.pc_E      = 32'h0000_3000;
        bus.instr_E   = 32'h0085_3020;
        bus.rt_data_E = 32'h1234_5678;
    endtask

    initial begin
        reset = 1'b1;
        rand_data();
        {bus.req, bus.en, bus.clr} = 3'b110;
        exp_s = '{pc: 0, instr: 0, ans: 0, rt: 0, wa: 0, bd: 0, ev: 0, ec: 0, v: 0};
        step();
        check("reset_valid", 32'(bus.valid_M), 32'd0);
        reset = 1'b0;
        plain(32'h0000_0005, 5'd8);
        step();
        check("add_ans", bus.ans_M, 32'd5);
        check("add_wa", 32'(bus.wa_M), 32'd8);
        plain(32'h7fff_0000, 5'd8);
        bus.alu_ov_E = 1'b1;
        step();
        check("ov_code", 32'(bus.exc_M), 32'd12);
        plain(32'h8000_0000, 5'd9);
        {bus.is_load_E, bus.alu_esl_E} = 2'b11;
        step();
        check("adel_code", 32'(bus.exc_M), 32'd4);
        check("adel_badva", bus.ans_M, 32'h8000_0000);
        plain(32'h8000_0000, 5'd0);
        {bus.is_store_E, bus.alu_esl_E} = 2'b11;
        step();
        check("ades_code", 32'(bus.exc_M), 32'd5);
        {bus.is_load_E, bus.is_store_E, bus.alu_esl_E} = 3'b111;
        step();
        check("ld_st_code", 32'(bus.exc_M), 32'd4);
        plain(32'h1, 5'd3);
        {bus.exc_vld_E, bus.exc_E, bus.alu_ov_E} = {1'b1, 5'd10, 1'b1};
        step();
        check("upstream_code", 32'(bus.exc_M), 32'd10);
        plain(32'h1, 5'd3);
        {bus.req, bus.clr, bus.en} = 3'b110;
        step();
        check("flush_pc", bus.pc_M, 32'h0000_4180);
        plain(32'h55, 5'd7);
        bus.clr  = 1'b1;
        bus.pc_E = 32'h0000_3008;
        bus.bd_E = 1'b1;
        step();
        check("bubble_pc", bus.pc_M, 32'h0000_3008);
        check("bubble_bd", 32'(bus.bd_M), 32'd1);
        plain(32'h66, 5'd6);
        step();
        for (int i = 0; i < 3; i++) begin
            rand_data();
            {bus.req, bus.en, bus.clr} = {2'b00, 1'(i)};
            step();
            check("hold_ans", bus.ans_M, 32'h66);
        end
        for (int i = 0; i < 400; i++) begin
            rand_data();
            reset   = $urandom_range(0, 31) == 0;
            bus.req = $urandom_range(0, 15) == 0;
            bus.en  = $urandom_range(0, 3) != 0;
            bus.clr = $urandom_range(0, 7) == 0;
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- E→M pipeline register of the P7 five-stage MIPS core; sits directly downstream of the E-stage arithmetic unit.
- Captures the ALU result, store data, write address, PC/instruction and branch-delay flag at each clock edge.
- Folds the ALU overflow flags into the M-stage exception code: Ov for arithmetic instructions, AdEL/AdES for load/store address calculation. Upstream exceptions keep priority.
- Implements hold, bubble and interrupt/exception flush.

Parameters:
- PC_HANDLER, 32'h0000_4180, PC loaded into pc_M on req flush.
- EXC_W, 5, exception-code width (CP0 Cause.ExcCode).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- req  in  1  CP0 exception/interrupt request; flushes this stage
- en  in  1  load enable; 0 = hold all registers
- clr  in  1  insert bubble (data cleared, pc/bd kept)
- pc_E  in  32  E-stage PC
- instr_E  in  32  E-stage instruction word
- alu_ans_E  in  32  ALU result
- alu_ov_E  in  1  ALU overflow, already gated by cal_E
- alu_esl_E  in  1  ALU raw signed overflow of add/sub
- is_load_E  in  1  instruction is a load
- is_store_E  in  1  instruction is a store
- rt_data_E  in  32  forwarded rt value (store data)
- wa_E  in  5  GRF write address
- bd_E  in  1  instruction is in a branch delay slot
- exc_vld_E  in  1  upstream exception pending
- exc_E  in  EXC_W  upstream exception code
- pc_M  out  32  registered PC
- instr_M  out  32  registered instruction
- ans_M  out  32  registered ALU result / memory address
- rt_data_M  out  32  registered store data
- wa_M  out  5  registered write address (0 = no write)
- bd_M  out  1  registered delay-slot flag
- exc_vld_M  out  1  exception pending in M
- exc_M  out  EXC_W  exception code in M
- valid_M  out  1  stage holds a real instruction (not a bubble)

Behaviour:
- All updates occur on the rising clk edge. Priority order: reset > req > !en (hold) > clr > normal load.
- Reset: every output is 0, including pc_M=0 and valid_M=0.
- req=1: pc_M=PC_HANDLER; all other outputs 0.
- en=0: all outputs hold their values; clr is ignored.
- clr=1 (en=1): pc_M=pc_E and bd_M=bd_E, so the macroscopic PC stays correct. All other outputs 0, valid_M=0.
- Normal load: all fields copy from E, valid_M=1. Exception merge uses this priority:
  - exc_vld_E=1: exc_M=exc_E (earlier-stage exception wins).
  - else alu_ov_E=1: exc_M=12 (Ov).
  - else is_load_E & alu_esl_E: exc_M=4 (AdEL).
  - else is_store_E & alu_esl_E: exc_M=5 (AdES).
  - else exc_vld_M=0, exc_M=0.
- When exc_vld_M=1 after a load, wa_M is forced to 0 so the faulting instruction does not write back. ans_M still holds the ALU value, used as BadVAddr for AdEL/AdES.
- Latency is exactly 1 cycle. There is no combinational path from inputs to outputs.
- alu_esl_E is ignored unless is_load_E or is_store_E is set. Otherwise alu_ov_E is the only ALU-sourced exception.
- If is_load_E and is_store_E are both 1 (illegal decode), AdEL wins.

Decomposition:
- Shared package: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYSCALL=8, EXC_RI=10, EXC_OV=12, and PC_HANDLER. The CP0 and other pipeline registers reuse these.
- Exception-priority merge is a function in the package (exc_merge).
- No sub-module; a single flat register stage.

Test Plan:
- Reset: assert reset with nonzero inputs → next edge all outputs 0, valid_M=0.
- Normal add: alu_ans_E=32'h0000_0005, wa_E=8, no flags → ans_M=5, wa_M=8, exc_vld_M=0, valid_M=1.
- Arithmetic overflow: alu_ov_E=1, wa_E=8 → exc_vld_M=1, exc_M=12, wa_M=0.
- Load address overflow: is_load_E=1, alu_esl_E=1, alu_ans_E=32'h8000_0000 → exc_M=4, ans_M=32'h8000_0000. Same with is_store_E=1 → exc_M=5.
- Upstream priority: exc_vld_E=1, exc_E=10, alu_ov_E=1 → exc_M=10.
- Control priority:
  - req=1 with clr=1 and en=0 → pc_M=32'h0000_4180, all else 0.
  - clr=1, pc_E=32'h3008, bd_E=1 → pc_M=32'h3008, bd_M=1, valid_M=0, instr_M=0.
  - en=0 for 3 cycles with changing inputs → outputs unchanged.
